ofm_readout: RTL and testbench
==============================

OFM_READOUT -- requirements
Module: ofm_readout

Interface
REQ-001 Parameter DATA_WIDTH, default 8, output-map element width in bits.
REQ-002 Parameter MAP_SIZE, default 32, input-map edge; the output map is (MAP_SIZE/2)x(MAP_SIZE/2) elements, 256 at default.
REQ-003 Parameter NUM_MAPS, default 64, number of output maps read per run.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle run request, normally the sequencer's finish pulse.
REQ-007 idle  output  1  high when no run is in progress.
REQ-008 done  output  1  one-cycle pulse at the end of a run.
REQ-009 ofm_rd  output  1  OFM buffer read strobe.
REQ-010 ofm_raddr  output  7  OFM buffer word address; map k is at address k.
REQ-011 ofm_readdata  input  DATA_WIDTH*(MAP_SIZE/2)^2 (2048)  OFM word; valid the cycle after ofm_rd.
REQ-012 m_valid  output  1  stream byte valid.
REQ-013 m_ready  input  1  stream sink ready.
REQ-014 m_data  output  DATA_WIDTH  stream element.
REQ-015 m_map  output  6  index of the map currently streaming.
REQ-016 m_last  output  1  high with the final element of map NUM_MAPS-1.

Function
REQ-017 The FSM SHALL have states IDLE, READ, CAPTURE, SEND and DONE.
REQ-018 IDLE: idle=1; start=1 SHALL move to READ with map counter=0.
REQ-019 READ: ofm_rd=1 and ofm_raddr=map counter for exactly one cycle, then CAPTURE.
REQ-020 CAPTURE: ofm_readdata SHALL be loaded into a 2048-bit holding register and the element counter cleared, then SEND.
REQ-021 SEND: m_valid=1; m_data=holding[(e+1)*DATA_WIDTH-1 : e*DATA_WIDTH] for element counter e, so element 0 (bits 7:0) goes first.
REQ-022 A transfer SHALL occur only on a cycle with m_valid=1 and m_ready=1; each transfer increments e.
REQ-023 While m_valid=1 and m_ready=0, m_data, m_map and m_last SHALL hold stable.
REQ-024 On the transfer of e=255: if map counter<NUM_MAPS-1, increment the map counter and go to READ; otherwise go to DONE.
REQ-025 DONE: done=1 for one cycle, then IDLE with idle=1 on the following cycle.
REQ-026 m_last SHALL equal (map counter==NUM_MAPS-1 && e==255 && state==SEND).
REQ-027 m_valid, ofm_rd and done SHALL be 0 in all states other than SEND, READ and DONE respectively.
REQ-028 start outside IDLE SHALL be ignored and not queued.
REQ-029 idle SHALL drop the cycle after start is accepted and remain 0 through DONE.
REQ-030 Per map, READ->SEND overhead SHALL be exactly 2 cycles; at m_ready=1 constant, a run lasts NUM_MAPS*258+1 cycles from start to done.
REQ-031 Counters SHALL NOT wrap: e ranges 0..255 and the map counter 0..NUM_MAPS-1.

Reset
REQ-032 rst_n=0 SHALL force state IDLE, idle=1, done=0, ofm_rd=0, ofm_raddr=0, m_valid=0, m_data=0, m_map=0, m_last=0, all counters and the holding register to 0.
REQ-033 Reset asserted mid-run SHALL abort the run immediately without a done pulse; the next run restarts at map 0.

Verification
REQ-034 Reset release, then start at cycle t -> ofm_rd=1, raddr=0 at t+1; m_valid=1 at t+3 with m_data=word0[7:0].
REQ-035 m_ready=1 constant, memory word k byte j = (k+j) mod 256 -> 16384 bytes in order, m_last on the last byte only, done once at cycle t+16513.
REQ-036 m_ready toggling randomly 50% -> identical byte sequence to REQ-035; m_data/m_map stable during every stall.
REQ-037 start pulsed again at map 10 -> no effect, no restart; extra start after done -> new run from map 0.
REQ-038 rst_n low during map 20, e=100 -> all outputs at reset values asynchronously, no done; new start -> streaming from map 0.

Source files
------------

// File: rtl/ofm_readout.sv
// Reads NUM_MAPS output-map words from the OFM buffer, one per map, and streams
// each word out element by element over a valid/ready byte stream.
module ofm_readout #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAP_SIZE   = 32,
   parameter int unsigned NUM_MAPS   = 64
) (
   input  logic                                                    clk,
   input  logic                                                    rst_n,
   input  logic                                                    start,
   output logic                                                    idle,
   output logic                                                    done,
   output logic                                                    ofm_rd,
   output logic [6:0]                                              ofm_raddr,
   input  logic [DATA_WIDTH*(MAP_SIZE/2)*(MAP_SIZE/2)-1:0]         ofm_readdata,
   output logic                                                    m_valid,
   input  logic                                                    m_ready,
   output logic [DATA_WIDTH-1:0]                                   m_data,
   output logic [5:0]                                              m_map,
   output logic                                                    m_last
);

   localparam int unsigned ELEMS   = (MAP_SIZE / 2) * (MAP_SIZE / 2);
   localparam int unsigned WORD_W  = DATA_WIDTH * ELEMS;
   localparam int unsigned E_W     = $clog2(ELEMS);
   localparam int unsigned MAP_W   = 6;
   localparam int unsigned RADDR_W = 7;

   localparam logic [E_W-1:0]   LAST_E   = E_W'(ELEMS - 1);
   localparam logic [MAP_W-1:0] LAST_MAP = MAP_W'(NUM_MAPS - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      CAPTURE,
      SEND,
      DONE
   } state_t;

   state_t                 state_q, state_d;
   logic [MAP_W-1:0]       map_q, map_d;
   logic [E_W-1:0]         e_q, e_d;
   logic [WORD_W-1:0]      hold_q, hold_d;
   logic                   idle_q, idle_d;
   logic                   done_q, done_d;
   logic                   rd_q, rd_d;
   logic                   valid_q, valid_d;
   logic [DATA_WIDTH-1:0]  data_q, data_d;
   logic                   last_q, last_d;

   // State, counters, holding word and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         map_q   <= '0;
         e_q     <= '0;
         hold_q  <= '0;
         idle_q  <= 1'b1;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         map_q   <= map_d;
         e_q     <= e_d;
         hold_q  <= hold_d;
         idle_q  <= idle_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   // Next state; outputs are decoded from the next state so they register in step with it
   always_comb begin
      state_d = state_q;
      map_d   = map_q;
      e_d     = e_q;
      hold_d  = hold_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = READ;
               map_d   = '0;
            end
         end
         READ: begin
            state_d = CAPTURE;
         end
         CAPTURE: begin
            hold_d  = ofm_readdata;
            e_d     = '0;
            state_d = SEND;
         end
         SEND: begin
            if (m_ready) begin
               if (e_q == LAST_E) begin
                  if (map_q == LAST_MAP) begin
                     state_d = DONE;
                  end else begin
                     map_d   = map_q + MAP_W'(1);
                     state_d = READ;
                  end
               end else begin
                  e_d = e_q + E_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      idle_d  = (state_d == IDLE);
      done_d  = (state_d == DONE);
      rd_d    = (state_d == READ);
      valid_d = (state_d == SEND);
      data_d  = valid_d ? hold_d[32'(e_d) * DATA_WIDTH +: DATA_WIDTH] : '0;
      last_d  = valid_d && (map_d == LAST_MAP) && (e_d == LAST_E);
   end

   assign idle      = idle_q;
   assign done      = done_q;
   assign ofm_rd    = rd_q;
   assign ofm_raddr = RADDR_W'(map_q);
   assign m_valid   = valid_q;
   assign m_data    = data_q;
   assign m_map     = map_q;
   assign m_last    = last_q;

endmodule

// File: tb/tb_ofm_readout.sv
// Randomized self-checking bench for ofm_readout against a queue-based model of
// the expected element stream built directly from the OFM memory contents.
module tb_ofm_readout;

   localparam int unsigned DW       = 8;
   localparam int unsigned MS       = 32;
   localparam int unsigned NM       = 64;
   localparam int unsigned ELEMS    = (MS / 2) * (MS / 2);
   localparam int unsigned WORD_W   = DW * ELEMS;
   localparam int          RUN_CYC  = NM * 258 + 1;
   localparam int          BUDGET   = 60000;

   typedef struct {
      logic [7:0] data;
      int         map;
      bit         last;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              idle;
   logic              done;
   logic              ofm_rd;
   logic [6:0]        ofm_raddr;
   logic [WORD_W-1:0] ofm_readdata;
   logic              m_valid;
   logic              m_ready;
   logic [DW-1:0]     m_data;
   logic [5:0]        m_map;
   logic              m_last;

   logic [WORD_W-1:0] mem [NM];
   beat_t             exp_q [$];
   int                errors = 0;
   int                checks = 0;

   ofm_readout #(.DATA_WIDTH(DW), .MAP_SIZE(MS), .NUM_MAPS(NM)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .idle         (idle),
      .done         (done),
      .ofm_rd       (ofm_rd),
      .ofm_raddr    (ofm_raddr),
      .ofm_readdata (ofm_readdata),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .m_map        (m_map),
      .m_last       (m_last)
   );

   always #5 clk = ~clk;

   // OFM buffer: word valid only in the cycle after the read strobe
   always @(posedge clk) begin
      if (ofm_rd) ofm_readdata <= mem[ofm_raddr[5:0]];
      else        ofm_readdata <= '1;
   end

   task automatic fill_pattern();
      for (int k = 0; k < NM; k++)
         for (int j = 0; j < ELEMS; j++)
            mem[k][j*DW +: DW] = 8'((k + j) % 256);
   endtask

   task automatic fill_random();
      for (int k = 0; k < NM; k++)
         for (int w = 0; w < WORD_W / 32; w++)
            mem[k][w*32 +: 32] = $urandom;
   endtask

   task automatic build_model();
      beat_t b;
      exp_q.delete();
      for (int k = 0; k < NM; k++)
         for (int j = 0; j < ELEMS; j++) begin
            b.data = mem[k][j*DW +: DW];
            b.map  = k;
            b.last = (k == NM - 1) && (j == ELEMS - 1);
            exp_q.push_back(b);
         end
   endtask

   // Starts a run and checks every cycle; returns after the post-done cycle,
   // or early (with m_valid high) once stop_after elements have transferred.
   task automatic run_stream(input bit rand_ready, input int restart_map, input int stop_after);
      beat_t      b;
      int         popped = 0;
      int         reads  = 0;
      bit         pulsed = 0;
      bit         stall  = 0;
      logic [7:0] sd;
      logic [5:0] sm;
      logic       sl;
      logic [7:0] first_byte;
      build_model();
      first_byte = mem[0][7:0];
      @(negedge clk);
      start   = 1'b1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      for (int c = 1; c <= BUDGET; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 1) begin
            checks++;
            if (ofm_rd !== 1'b1 || ofm_raddr !== 7'd0 || idle !== 1'b0)
               $display("FAIL first_read: rd=%b raddr=%0d idle=%b, want rd=1 raddr=0 idle=0",
                        ofm_rd, ofm_raddr, idle);
            if (ofm_rd !== 1'b1 || ofm_raddr !== 7'd0 || idle !== 1'b0) errors++;
         end
         if (c == 3) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== first_byte) begin
               errors++;
               $display("FAIL first_valid: valid=%b data=%h, want valid=1 data=%h",
                        m_valid, m_data, first_byte);
            end
         end
         if (ofm_rd === 1'b1) begin
            checks++;
            if (ofm_raddr !== 7'(reads)) begin
               errors++;
               $display("FAIL read_addr: raddr=%0d, want %0d", ofm_raddr, reads);
            end
            reads++;
         end
         if (stall) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== sd || m_map !== sm || m_last !== sl) begin
               errors++;
               $display("FAIL stall_hold: valid=%b data=%h map=%0d last=%b, want 1 %h %0d %b",
                        m_valid, m_data, m_map, m_last, sd, sm, sl);
            end
         end
         if (m_valid === 1'b1) begin
            if (stop_after >= 0 && popped == stop_after) return;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: data=%h map=%0d beyond end of run", m_data, m_map);
            end else begin
               b = exp_q[0];
               if (m_data !== b.data || m_map !== 6'(b.map) || m_last !== b.last) begin
                  errors++;
                  $display("FAIL beat %0d: data=%h map=%0d last=%b, want data=%h map=%0d last=%b",
                           popped, m_data, m_map, m_last, b.data, b.map, b.last);
               end
            end
         end else begin
            checks++;
            if (m_last !== 1'b0) begin
               errors++;
               $display("FAIL last_idle: m_last=%b without m_valid, want 0", m_last);
            end
         end
         if (done === 1'b1) begin
            checks++;
            if (exp_q.size() != 0 || (!rand_ready && c != RUN_CYC)) begin
               errors++;
               $display("FAIL done_timing: cycle=%0d left=%0d, want cycle=%0d left=0",
                        c, exp_q.size(), RUN_CYC);
            end
            @(negedge clk);
            checks++;
            if (idle !== 1'b1 || done !== 1'b0 || m_valid !== 1'b0) begin
               errors++;
               $display("FAIL after_done: idle=%b done=%b valid=%b, want 1 0 0",
                        idle, done, m_valid);
            end
            return;
         end else begin
            checks++;
            if (idle !== 1'b0) begin
               errors++;
               $display("FAIL idle_in_run: idle=%b at cycle %0d, want 0", idle, c);
            end
         end
         if (restart_map >= 0 && !pulsed && m_valid === 1'b1 && m_map == 6'(restart_map)) begin
            start  = 1'b1;
            pulsed = 1'b1;
         end
         m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         stall   = (m_valid === 1'b1) && !m_ready;
         sd = m_data;
         sm = m_map;
         sl = m_last;
         if (m_valid === 1'b1 && m_ready && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            popped++;
         end
      end
      errors++;
      $display("FAIL run_timeout: no done within %0d cycles, popped=%0d", BUDGET, popped);
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      start   = 1'b0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (idle !== 1'b1 || done !== 1'b0 || ofm_rd !== 1'b0 || ofm_raddr !== 7'd0 ||
          m_valid !== 1'b0 || m_data !== 8'd0 || m_map !== 6'd0 || m_last !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: idle=%b done=%b rd=%b raddr=%0d valid=%b data=%h map=%0d last=%b",
                  idle, done, ofm_rd, ofm_raddr, m_valid, m_data, m_map, m_last);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (idle !== 1'b1 || ofm_rd !== 1'b0 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start: idle=%b rd=%b valid=%b, want 1 0 0", idle, ofm_rd, m_valid);
      end
   endtask

   task automatic test_stream_restart_ignored();
      fill_pattern();
      run_stream(1'b0, 10, -1);
   endtask

   task automatic test_back_to_back();
      run_stream(1'b1, -1, -1);
   endtask

   task automatic test_reset_abort();
      fill_pattern();
      run_stream(1'b1, -1, 20 * ELEMS + 100);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (idle !== 1'b1 || done !== 1'b0 || ofm_rd !== 1'b0 || ofm_raddr !== 7'd0 ||
          m_valid !== 1'b0 || m_data !== 8'd0 || m_map !== 6'd0 || m_last !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: idle=%b done=%b rd=%b raddr=%0d valid=%b data=%h map=%0d last=%b",
                  idle, done, ofm_rd, ofm_raddr, m_valid, m_data, m_map, m_last);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: done=%b idle=%b, want 0 1", done, idle);
         end
      end
      rst_n = 1'b1;
      fill_random();
      run_stream(1'b1, -1, 600);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_stream_restart_ignored();
      test_back_to_back();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
